// File: rtl/hs400_tuning_pkg.sv
// Shared types and constants for the HS400 tuning path: probe FSM states,
// parameter defaults and the legal data-strobe capture patterns.
package hs400_tuning_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_VERIFY,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } probe_state_t;

   localparam int DEF_TAP_W         = 5;
   localparam int DEF_SETTLE_CYCLES = 16;
   localparam int DEF_SAMPLE_CYCLES = 256;

   // A centred strobe toggles between the rising and falling capture flops.
   localparam logic [1:0] DS_PAT_A = 2'b01;
   localparam logic [1:0] DS_PAT_B = 2'b10;

   function automatic logic ds_pat_valid(input logic [1:0] pat);
      return (pat == DS_PAT_A) || (pat == DS_PAT_B);
   endfunction

endpackage

// File: rtl/hs400_ds_pattern_chk.sv
// DDR strobe pattern checker: latches the first sample as reference and counts
// (saturating) every later sample that differs, plus an illegal reference.
module hs400_ds_pattern_chk
   import hs400_tuning_pkg::*;
#(
   parameter int ERR_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_start,
   input  logic             i_en,
   input  logic [1:0]       i_ds,
   output logic [ERR_W-1:0] o_err_cnt,
   output logic [ERR_W-1:0] o_err_nxt
);

   logic [1:0]       r_ref;
   logic [ERR_W-1:0] r_err;
   logic             w_hit;

   always_comb begin
      w_hit     = 1'b0;
      o_err_nxt = r_err;
      if (i_start) begin
         w_hit = !ds_pat_valid(i_ds);
      end else if (i_en) begin
         w_hit = (i_ds != r_ref);
      end
      if (i_clr) begin
         o_err_nxt = '0;
      end else if (i_start) begin
         o_err_nxt = ERR_W'(w_hit);
      end else if (w_hit && (r_err != '1)) begin
         o_err_nxt = r_err + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ref <= 2'b00;
         r_err <= '0;
      end else begin
         r_err <= o_err_nxt;
         if (i_start) begin
            r_ref <= i_ds;
         end
      end
   end

   assign o_err_cnt = r_err;

endmodule

// File: rtl/hs400_tap_probe.sv
// Per-tap IDELAY measurement engine: load a tap, verify the readback, let the
// delay line settle, then grade the captured data strobe over a fixed window.
module hs400_tap_probe
   import hs400_tuning_pkg::*;
#(
   parameter int TAP_W         = DEF_TAP_W,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
   parameter int ERR_W         = $clog2(SAMPLE_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             probe_req,
   input  logic [TAP_W-1:0] probe_tap,
   output logic             probe_busy,
   output logic             probe_ack,
   output logic             probe_pass,
   output logic             probe_load_err,
   output logic [ERR_W-1:0] probe_err_cnt,
   input  logic [1:0]       data_strobe,
   output logic [TAP_W-1:0] cntval_in,
   output logic             cntval_load,
   input  logic [TAP_W-1:0] cntval_out,
   output logic [2:0]       o_dbg_state
);

   localparam int MAX_CYC = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SAMPLE_CYCLES - 1);

   probe_state_t     r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             w_clr;
   logic             w_start;
   logic             w_en;
   logic [ERR_W-1:0] w_err_nxt;

   // Handshake: probe_req is taken only in IDLE (no queueing); probe_ack pulses
   // once per accepted request and the result outputs hold until the next LOAD.
   assign w_clr   = (r_state == ST_IDLE) && probe_req;
   assign w_en    = (r_state == ST_SAMPLE);
   assign w_start = w_en && (r_cnt == SAMPLE_LD);

   hs400_ds_pattern_chk #(
      .ERR_W (ERR_W)
   ) u_ds_chk (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_clr),
      .i_start   (w_start),
      .i_en      (w_en),
      .i_ds      (data_strobe),
      .o_err_cnt (probe_err_cnt),
      .o_err_nxt (w_err_nxt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         cntval_in      <= '0;
         cntval_load    <= 1'b0;
         probe_busy     <= 1'b0;
         probe_ack      <= 1'b0;
         probe_pass     <= 1'b0;
         probe_load_err <= 1'b0;
      end else begin
         cntval_load <= 1'b0;
         probe_ack   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (probe_req) begin
                  r_state        <= ST_LOAD;
                  cntval_in      <= probe_tap;
                  cntval_load    <= 1'b1;
                  probe_busy     <= 1'b1;
                  probe_pass     <= 1'b0;
                  probe_load_err <= 1'b0;
               end
            end
            ST_LOAD: begin
               r_state <= ST_VERIFY;
            end
            ST_VERIFY: begin
               if (cntval_out != cntval_in) begin
                  r_state        <= ST_DONE;
                  probe_load_err <= 1'b1;
                  probe_pass     <= 1'b0;
                  probe_ack      <= 1'b1;
               end else begin
                  r_state <= ST_SETTLE;
                  r_cnt   <= SETTLE_LD;
               end
            end
            ST_SETTLE: begin
               if (r_cnt == '0) begin
                  r_state <= ST_SAMPLE;
                  r_cnt   <= SAMPLE_LD;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_SAMPLE: begin
               // The last sample lands on this same edge, so grade from the next count.
               if (r_cnt == '0) begin
                  r_state    <= ST_DONE;
                  probe_ack  <= 1'b1;
                  probe_pass <= (w_err_nxt == '0);
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_DONE: begin
               r_state    <= ST_IDLE;
               probe_busy <= 1'b0;
            end
            default: begin
               r_state    <= ST_IDLE;
               probe_busy <= 1'b0;
            end
         endcase
      end
   end

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_hs400_tap_probe.sv
// Bench for hs400_tap_probe: scoreboard of expected loads and results fed by
// the stimulus tasks, a negedge monitor, and a small saturation instance.
module tb_hs400_tap_probe;

   localparam int TAP_W  = 5;
   localparam int S      = 16;
   localparam int N      = 256;
   localparam int ERR_W  = $clog2(N + 1);
   localparam int SAT_S  = 2;
   localparam int SAT_N  = 4;
   localparam int SAT_EW = 2;
   localparam int EXP_W  = 32 + TAP_W + 2 + ERR_W;
   localparam int LD_W   = 32 + TAP_W;

   logic clk = 1'b0;
   logic rst;
   logic req;
   logic sat_req;
   logic [TAP_W-1:0] tap;
   logic [1:0] ds;
   logic [TAP_W-1:0] corrupt;

   logic busy, ack, pass, lerr, cld;
   logic [ERR_W-1:0] ecnt;
   logic [TAP_W-1:0] cin;
   logic [TAP_W-1:0] idly = '0;
   logic [2:0] dbg;

   logic s_busy, s_ack, s_pass, s_lerr, s_cld;
   logic [SAT_EW-1:0] s_ecnt;
   logic [TAP_W-1:0] s_cin;
   logic [TAP_W-1:0] s_idly = '0;
   logic [2:0] s_dbg;

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   bit chk_idle = 1'b0;
   logic [EXP_W-1:0] exp_q[$];
   logic [LD_W-1:0] ld_q[$];
   logic [1:0] plan [0:N-1];

   hs400_tap_probe u_dut (
      .clk(clk), .rst(rst), .probe_req(req), .probe_tap(tap),
      .probe_busy(busy), .probe_ack(ack), .probe_pass(pass),
      .probe_load_err(lerr), .probe_err_cnt(ecnt), .data_strobe(ds),
      .cntval_in(cin), .cntval_load(cld), .cntval_out(idly), .o_dbg_state(dbg)
   );

   hs400_tap_probe #(
      .TAP_W(TAP_W), .SETTLE_CYCLES(SAT_S), .SAMPLE_CYCLES(SAT_N), .ERR_W(SAT_EW)
   ) u_dut_sat (
      .clk(clk), .rst(rst), .probe_req(sat_req), .probe_tap(tap),
      .probe_busy(s_busy), .probe_ack(s_ack), .probe_pass(s_pass),
      .probe_load_err(s_lerr), .probe_err_cnt(s_ecnt), .data_strobe(ds),
      .cntval_in(s_cin), .cntval_load(s_cld), .cntval_out(s_idly), .o_dbg_state(s_dbg)
   );

   // ---------------- clock / IDELAY models ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (cld) idly <= cin ^ corrupt;
   always @(posedge clk) if (s_cld) s_idly <= s_cin;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: first sample is the reference, an illegal reference is one
   // error, every later differing sample is one error, clamp at the max.
   function automatic int model_err(input int n, input int maxv);
      int e;
      e = (plan[0] == 2'b01 || plan[0] == 2'b10) ? 0 : 1;
      for (int i = 1; i < n; i++) if (plan[i] != plan[0]) e++;
      return (e > maxv) ? maxv : e;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [LD_W-1:0] le;
      logic [EXP_W-1:0] ee;
      if (rst) begin
         if (chk_idle) begin
            check("busy_after_ack", busy, 0);
            chk_idle = 1'b0;
         end
         if (cld) begin
            if (ld_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_load: cntval_load with tap %0d, none expected", cin);
            end else begin
               le = ld_q.pop_front();
               check("load_cycle", cyc, le[LD_W-1:TAP_W]);
               check("load_tap", cin, le[TAP_W-1:0]);
            end
         end
         if (ack) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_ack: probe_ack at cycle %0d, no result expected", cyc);
            end else begin
               ee = exp_q.pop_front();
               check("ack_cycle", cyc, ee[EXP_W-1:EXP_W-32]);
               check("ack_cntval_in", cin, ee[ERR_W+2+TAP_W-1:ERR_W+2]);
               check("ack_load_err", lerr, ee[ERR_W+1]);
               check("ack_pass", pass, ee[ERR_W]);
               check("ack_err_cnt", ecnt, ee[ERR_W-1:0]);
               check("busy_at_ack", busy, 1);
               chk_idle = 1'b1;
            end
         end
      end
   end

   // ---------------- drivers ----------------
   // mode 0: steady 01; 1: 01 with three 11 glitches; 2: random base + random
   // glitches; 3: fully random. abort_at > 0 asserts reset at that cycle offset.
   task automatic run_probe(input logic [TAP_W-1:0] t, input logic [TAP_W-1:0] cmask,
                            input int mode, input bit intrude, input int abort_at);
      int k, err_e, ack_c, nf;
      bit lerr_e, pass_e, done;
      logic [1:0] base;
      base = (mode == 2 && $urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
      for (int i = 0; i < N; i++) plan[i] = (mode == 3) ? 2'($urandom_range(0, 3)) : base;
      if (mode == 1) begin
         plan[10] = 2'b11; plan[100] = 2'b11; plan[200] = 2'b11;
      end
      if (mode == 2) begin
         nf = $urandom_range(0, 3);
         for (int f = 0; f < nf; f++) plan[$urandom_range(1, N - 1)] = 2'b11;
      end
      @(negedge clk);
      k = cyc; tap = t; corrupt = cmask; req = 1'b1;
      lerr_e = (cmask != '0);
      err_e  = lerr_e ? 0 : model_err(N, (1 << ERR_W) - 1);
      pass_e = !lerr_e && (err_e == 0);
      ack_c  = lerr_e ? k + 3 : k + 3 + S + N;
      ld_q.push_back({32'(k + 1), t});
      exp_q.push_back({32'(ack_c), t, lerr_e, pass_e, ERR_W'(err_e)});
      @(negedge clk);
      req = 1'b0; tap = TAP_W'($urandom);
      done = 1'b0;
      for (int j = 2; j <= 3 + S + N + 4 && !done; j++) begin
         @(negedge clk);
         if (!busy) begin
            done = 1'b1;
         end else if (j == abort_at) begin
            rst = 1'b0;
            #1;
            check("rst_busy", busy, 0);
            check("rst_ack", ack, 0);
            check("rst_pass", pass, 0);
            check("rst_load_err", lerr, 0);
            check("rst_err_cnt", ecnt, 0);
            check("rst_cntval_in", cin, 0);
            check("rst_cntval_load", cld, 0);
            void'(exp_q.pop_back());
            repeat (2) @(negedge clk);
            rst = 1'b1;
            done = 1'b1;
         end else begin
            ds = (j >= 3 + S && j <= 2 + S + N) ? plan[j - 3 - S] : 2'($urandom_range(0, 3));
            if (intrude) begin
               req = (j == 3 + S + 10);
               if (j == 3 + S + 10) tap = 5'd20;
            end
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL probe_timeout: busy=%0b after %0d cycles", busy, 3 + S + N + 4);
      end
   endtask

   task automatic run_sat();
      int k, err_e;
      bit seen;
      plan[0] = 2'b00; plan[1] = 2'b11; plan[2] = 2'b01; plan[3] = 2'b10;
      err_e = model_err(SAT_N, (1 << SAT_EW) - 1);
      @(negedge clk);
      k = cyc; tap = 5'd6; sat_req = 1'b1;
      @(negedge clk);
      sat_req = 1'b0;
      seen = 1'b0;
      for (int j = 2; j <= 20 && !seen; j++) begin
         @(negedge clk);
         if (s_ack) begin
            seen = 1'b1;
            check("sat_ack_cycle", cyc, k + 3 + SAT_S + SAT_N);
            check("sat_err_cnt", s_ecnt, err_e);
            check("sat_pass", s_pass, (err_e == 0));
            check("sat_load_err", s_lerr, 0);
         end
         ds = (j >= 3 + SAT_S && j <= 2 + SAT_S + SAT_N) ? plan[j - 3 - SAT_S] : 2'b01;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL sat_timeout: no probe_ack within 20 cycles");
      end
      repeat (3) @(negedge clk);
      check("sat_err_hold", s_ecnt, err_e);
      check("sat_busy_idle", s_busy, 0);
   endtask

   // ---------------- sequence ----------------
   initial begin
      logic [TAP_W-1:0] rt;
      rst = 1'b0; req = 1'b0; sat_req = 1'b0; tap = '0; ds = 2'b00; corrupt = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_ack", ack, 0);
      check("reset_pass", pass, 0);
      check("reset_load_err", lerr, 0);
      check("reset_err_cnt", ecnt, 0);
      check("reset_cntval_in", cin, 0);
      check("reset_cntval_load", cld, 0);
      check("reset_sat_err_cnt", s_ecnt, 0);
      rst = 1'b1;
      @(negedge clk);

      run_probe(5'd12, '0, 0, 1'b0, 0);           // clean strobe
      run_probe(5'd5, '0, 1, 1'b0, 0);            // marginal: 3 glitches
      run_probe(5'd9, 5'd9 ^ 5'd7, 0, 1'b0, 0);   // readback 7 for 9
      run_probe(5'd12, '0, 0, 1'b1, 0);           // request during SAMPLE ignored
      run_probe(5'd17, '0, 0, 1'b0, 3 + 5);       // reset mid-SETTLE
      run_probe(5'd3, '0, 0, 1'b0, 0);            // recovery after reset
      run_sat();

      for (int n = 0; n < 10; n++) begin
         rt = TAP_W'($urandom);
         run_probe(rt, ($urandom_range(0, 4) == 0) ? TAP_W'($urandom_range(1, 31)) : '0,
                   $urandom_range(0, 3), 1'b0, 0);
      end

      repeat (3) @(negedge clk);
      check("pending_results", exp_q.size(), 0);
      check("pending_loads", ld_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
